// File: rtl/del_3_serial.sv
// Bit-serial word assembler with running mod-3 remainder FSM (MSB first).
// Optional reference cross-check of each word's remainder: DEL3_SERIAL_CHECK_EN.
module del_3_serial #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bit_in,
   input  logic              bit_valid,
   input  logic              sync,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic [1:0]        rem,
   output logic              divisibility,
   output logic              busy,
   output logic              chk_err
);

   localparam int CW = $clog2(DATA_W);
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   typedef enum logic [1:0] {R0 = 2'd0, R1 = 2'd1, R2 = 2'd2} rem_state_t;

   rem_state_t        state, state_nxt, base_st, step_st;
   logic [CW-1:0]     cnt, cnt_nxt, base_cnt;
   logic [DATA_W-1:0] sr, sr_nxt;
   logic              done;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= R0;
         cnt   <= '0;
         sr    <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         sr    <= sr_nxt;
      end
   end

   // sync restarts alignment, and a bit in the same cycle becomes bit 0
   always_comb begin
      base_st   = sync ? R0 : state;
      base_cnt  = sync ? '0 : cnt;
      state_nxt = base_st;
      cnt_nxt   = base_cnt;
      sr_nxt    = sr;
      done      = 1'b0;
      case (base_st)
         R0:      step_st = bit_in ? R1 : R0;
         R1:      step_st = bit_in ? R0 : R2;
         R2:      step_st = bit_in ? R2 : R1;
         default: step_st = R0;
      endcase
      if (bit_valid) begin
         sr_nxt = {sr[DATA_W-2:0], bit_in};
         if (base_cnt == LAST) begin
            done      = 1'b1;
            cnt_nxt   = '0;
            state_nxt = R0;
         end else begin
            cnt_nxt   = base_cnt + CW'(1);
            state_nxt = step_st;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_out     <= '0;
         rem          <= 2'd0;
         divisibility <= 1'b1;
         data_valid   <= 1'b0;
      end else begin
         data_valid <= done;
         if (done) begin
            data_out     <= sr_nxt;
            rem          <= step_st;
            divisibility <= (step_st == R0);
         end
      end
   end

   assign busy = (cnt != '0);

`ifdef DEL3_SERIAL_CHECK_EN
   logic [1:0] ref_rem;
   assign ref_rem = 2'(data_out % DATA_W'(3));

   always_ff @(posedge clk) begin
      if (rst)
         chk_err <= 1'b0;
      else if (data_valid && (ref_rem != rem))
         chk_err <= 1'b1;
   end
`else
   assign chk_err = 1'b0;
`endif

endmodule
